// File: rtl/tcbm_tia_sequencer.sv
// TCBM byte-transfer sequencer: turns one-byte send/receive commands into 6523 TIA
// register bus ops, including the DAV/ACK handshake on port C and a port B status read.
module tcbm_tia_sequencer #(
    parameter int unsigned STROBE_CYCLES = 2,
    parameter int unsigned TIMEOUT_POLLS = 1023
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_dir,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic [1:0] rsp_status,
    output logic       rsp_timeout,
    output logic       tia_cs_n,
    output logic [2:0] tia_rs,
    output logic       tia_write_n,
    output logic [7:0] tia_data_out,
    output logic       tia_data_oe,
    input  logic [7:0] tia_data_in
);

    localparam int unsigned StrobeW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
    localparam logic [StrobeW-1:0] StrobeLast = StrobeW'(STROBE_CYCLES - 1);
    localparam logic [9:0] PollLast = 10'(TIMEOUT_POLLS - 1);

    localparam logic [2:0] RsPa   = 3'd0;
    localparam logic [2:0] RsPb   = 3'd1;
    localparam logic [2:0] RsPc   = 3'd2;
    localparam logic [2:0] RsDdra = 3'd3;
    localparam logic [2:0] RsDdrc = 3'd5;

    // StBoot only exists to load the first op's bus fields on the edge after reset
    typedef enum logic [3:0] {
        StBoot, StInitDdrc, StInitPc, StIdle, StSetDdra, StWrPa, StDavLo, StWaitAckLo,
        StRdPa, StDavHi, StWaitAckHi, StRdPb, StDone
    } state_t;

    typedef enum logic [1:0] {PhSetup, PhStrobe, PhHold} phase_t;

    state_t              state;
    state_t              op_next;
    state_t              launch_state;
    phase_t              phase;
    logic [StrobeW-1:0]  strobe_cnt;
    logic [9:0]          poll_cnt;
    logic                dir;
    logic                aborting;
    logic [7:0]          tx_byte;
    logic [7:0]          rx_byte;
    logic [7:0]          rd_data;
    logic [7:0]          pc_shadow;

    logic                in_op;
    logic                poll_again;
    logic                abort_now;
    logic                do_launch;
    logic                launch_dir;
    logic                launch_we;
    logic [2:0]          launch_rs;
    logic [7:0]          launch_wdata;

    assign in_op = !(state inside {StBoot, StIdle, StDone});

    // Op that follows the current one once its HOLD clock ends
    always_comb begin
        op_next    = StIdle;
        poll_again = 1'b0;
        abort_now  = 1'b0;
        unique case (state)
            StBoot:     op_next = StInitDdrc;
            StInitDdrc: op_next = StInitPc;
            StInitPc:   op_next = StIdle;
            StSetDdra:  op_next = dir ? StDavLo : StWrPa;
            StWrPa:     op_next = StDavLo;
            StDavLo:    op_next = StWaitAckLo;
            StWaitAckLo: begin
                if (!rd_data[6]) begin
                    op_next = dir ? StRdPa : StDavHi;
                end else if (poll_cnt == PollLast) begin
                    op_next   = StDavHi;
                    abort_now = 1'b1;
                end else begin
                    op_next    = StWaitAckLo;
                    poll_again = 1'b1;
                end
            end
            StRdPa:     op_next = StDavHi;
            StDavHi:    op_next = aborting ? StDone : StWaitAckHi;
            StWaitAckHi: begin
                if (rd_data[6]) begin
                    op_next = StRdPb;
                end else if (poll_cnt == PollLast) begin
                    op_next   = StDavHi;
                    abort_now = 1'b1;
                end else begin
                    op_next    = StWaitAckHi;
                    poll_again = 1'b1;
                end
            end
            StRdPb:     op_next = StDone;
            default:    op_next = StIdle;
        endcase
    end

    always_comb begin
        launch_state = op_next;
        launch_dir   = dir;
        do_launch    = 1'b0;
        if (state == StIdle) begin
            launch_state = StSetDdra;
            launch_dir   = cmd_dir;
            do_launch    = cmd_valid && cmd_ready;
        end else if (state == StBoot) begin
            do_launch = 1'b1;
        end else if (in_op && phase == PhHold) begin
            do_launch = !(op_next inside {StIdle, StDone});
        end

        launch_we    = 1'b1;
        launch_rs    = RsPc;
        launch_wdata = 8'h00;
        unique case (launch_state)
            StInitDdrc: begin
                launch_rs    = RsDdrc;
                launch_wdata = 8'h80;
            end
            StInitPc:   launch_wdata = pc_shadow;
            StSetDdra: begin
                launch_rs    = RsDdra;
                launch_wdata = launch_dir ? 8'h00 : 8'hFF;
            end
            StWrPa: begin
                launch_rs    = RsPa;
                launch_wdata = tx_byte;
            end
            StDavLo:    launch_wdata = {1'b0, pc_shadow[6:0]};
            StDavHi:    launch_wdata = {1'b1, pc_shadow[6:0]};
            StRdPa: begin
                launch_rs = RsPa;
                launch_we = 1'b0;
            end
            StRdPb: begin
                launch_rs = RsPb;
                launch_we = 1'b0;
            end
            default:    launch_we = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= StBoot;
            phase        <= PhSetup;
            strobe_cnt   <= '0;
            poll_cnt     <= '0;
            dir          <= 1'b0;
            aborting     <= 1'b0;
            tx_byte      <= 8'h00;
            rx_byte      <= 8'h00;
            rd_data      <= 8'h00;
            pc_shadow    <= 8'h80;
            cmd_ready    <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_data     <= 8'h00;
            rsp_status   <= 2'b00;
            rsp_timeout  <= 1'b0;
            tia_cs_n     <= 1'b1;
            tia_rs       <= 3'd0;
            tia_write_n  <= 1'b1;
            tia_data_out <= 8'h00;
            tia_data_oe  <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            if (state == StIdle && cmd_valid && cmd_ready) begin
                cmd_ready <= 1'b0;
                dir       <= cmd_dir;
                tx_byte   <= cmd_data;
            end
            if (state == StDone) begin
                cmd_ready <= 1'b1;
                state     <= StIdle;
            end
            if (in_op) begin
                unique case (phase)
                    PhSetup: begin
                        tia_cs_n   <= 1'b0;
                        strobe_cnt <= '0;
                        phase      <= PhStrobe;
                    end
                    PhStrobe: begin
                        if (strobe_cnt == StrobeLast) begin
                            tia_cs_n <= 1'b1;
                            phase    <= PhHold;
                            if (tia_write_n) rd_data <= tia_data_in;
                        end else begin
                            strobe_cnt <= strobe_cnt + StrobeW'(1);
                        end
                    end
                    PhHold: begin
                        poll_cnt <= poll_again ? poll_cnt + 10'd1 : 10'd0;
                        if (abort_now) aborting <= 1'b1;
                        if (state == StRdPa) rx_byte <= rd_data;
                        if (op_next == StIdle) begin
                            cmd_ready   <= 1'b1;
                            state       <= StIdle;
                            tia_write_n <= 1'b1;
                            tia_data_oe <= 1'b0;
                        end else if (op_next == StDone) begin
                            rsp_valid   <= 1'b1;
                            rsp_data    <= aborting ? 8'h00 : (dir ? rx_byte : tx_byte);
                            rsp_status  <= aborting ? 2'b11 : rd_data[1:0];
                            rsp_timeout <= aborting;
                            aborting    <= 1'b0;
                            state       <= StDone;
                            tia_write_n <= 1'b1;
                            tia_data_oe <= 1'b0;
                        end
                    end
                    default: phase <= PhSetup;
                endcase
            end
            if (do_launch) begin
                state        <= launch_state;
                phase        <= PhSetup;
                tia_cs_n     <= 1'b1;
                tia_rs       <= launch_rs;
                tia_write_n  <= !launch_we;
                tia_data_out <= launch_wdata;
                tia_data_oe  <= launch_we;
                if (launch_state inside {StDavLo, StDavHi}) pc_shadow <= launch_wdata;
            end
        end
    end

endmodule

// File: tb/tb_tcbm_tia_sequencer.sv
// Scoreboard bench for tcbm_tia_sequencer: expected bus ops and responses are queued by
// the stimulus and consumed by independent bus/response monitors; a peer model answers ACK.
module tb_tcbm_tia_sequencer;

    logic       clock;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_dir;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic [1:0] rsp_status;
    logic       rsp_timeout;
    logic       tia_cs_n;
    logic [2:0] tia_rs;
    logic       tia_write_n;
    logic [7:0] tia_data_out;
    logic       tia_data_oe;
    logic [7:0] tia_data_in;

    tcbm_tia_sequencer #(
        .STROBE_CYCLES (2),
        .TIMEOUT_POLLS (4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_dir      (cmd_dir),
        .cmd_data     (cmd_data),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rsp_status   (rsp_status),
        .rsp_timeout  (rsp_timeout),
        .tia_cs_n     (tia_cs_n),
        .tia_rs       (tia_rs),
        .tia_write_n  (tia_write_n),
        .tia_data_out (tia_data_out),
        .tia_data_oe  (tia_data_oe),
        .tia_data_in  (tia_data_in)
    );

    typedef struct {
        logic [7:0] data;
        logic [1:0] status;
        logic       timeout;
        int         lat;
    } rsp_t;

    rsp_t        rsp_q[$];
    logic [12:0] bus_q[$];   // {oe, write_n, rs, data}; data is 0 for reads

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int last_rsp_cyc = 0;
    int rsp_count = 0;
    bit skip_len = 0;

    // Peer model state
    logic [7:0] pa_val = 8'h00;
    logic [7:0] pb_val = 8'h00;
    int         lo_delay = 1;
    bit         stuck = 0;
    logic       dav = 1'b1;
    int         lo_reads = 0;
    logic       ack_now;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always_comb begin
        ack_now = 1'b1;
        if (!stuck && !dav && lo_reads >= lo_delay - 1) ack_now = 1'b0;
    end

    always_comb begin
        tia_data_in = 8'h00;
        case (tia_rs)
            3'd0:    tia_data_in = pa_val;
            3'd1:    tia_data_in = pb_val;
            3'd2:    tia_data_in = {dav, ack_now, 6'b0};
            default: tia_data_in = 8'h00;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [2:0] rs, input logic [7:0] d);
        bus_q.push_back({1'b1, 1'b0, rs, d});
    endtask

    task automatic rd(input logic [2:0] rs);
        bus_q.push_back({1'b0, 1'b1, rs, 8'h00});
    endtask

    task automatic exp_rsp(input logic [7:0] d, input logic [1:0] s, input logic t, input int lat);
        rsp_t r;
        r.data = d;
        r.status = s;
        r.timeout = t;
        r.lat = lat;
        rsp_q.push_back(r);
    endtask

    task automatic push_send(input logic [7:0] d, input int polls_lo);
        wr(3'd3, 8'hFF);
        wr(3'd0, d);
        wr(3'd2, 8'h00);
        repeat (polls_lo) rd(3'd2);
        wr(3'd2, 8'h80);
        rd(3'd2);
        rd(3'd1);
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 200) begin
            @(negedge clock);
            n++;
        end
        check(name, cmd_ready, 1);
    endtask

    task automatic issue(input logic d_dir, input logic [7:0] d);
        wait_ready("ready_before_issue");
        cmd_valid = 1'b1;
        cmd_dir   = d_dir;
        cmd_data  = d;
        @(negedge clock);
        cmd_valid = 1'b0;
    endtask

    task automatic count_init(input string name);
        int n = 0;
        while (n < 50) begin
            @(negedge clock);
            if (cmd_ready === 1'b1) break;
            n++;
        end
        check(name, n, 8);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((rsp_q.size() != 0 || bus_q.size() != 0) && n < 400) begin
            @(negedge clock);
            n++;
        end
        check({name, "_rsp_left"}, rsp_q.size(), 0);
        check({name, "_bus_left"}, bus_q.size(), 0);
        repeat (2) @(negedge clock);
    endtask

    // Cycle counter and accept-edge tracker
    initial forever begin
        @(posedge clock);
        cyc++;
        if (cmd_valid === 1'b1 && cmd_ready === 1'b1) acc_cyc = cyc;
    end

    // Bus monitor: checks each op as cs_n falls, and drives the peer's DAV/ACK view
    initial begin
        logic        prev_cs = 1'b1;
        int          low_cnt = 0;
        logic [12:0] cur = '0;
        logic [12:0] exp_op;
        forever begin
            @(negedge clock);
            if (tia_cs_n === 1'b0 && prev_cs === 1'b1) begin
                cur = {tia_data_oe, tia_write_n, tia_rs, tia_write_n ? 8'h00 : tia_data_out};
                low_cnt = 1;
                if (bus_q.size() == 0) begin
                    check("bus_unexpected_op", cur, 13'h0);
                end else begin
                    exp_op = bus_q.pop_front();
                    check("bus_op", cur, exp_op);
                end
                if (tia_write_n === 1'b0 && tia_rs === 3'd2) begin
                    dav = tia_data_out[7];
                    if (!tia_data_out[7]) lo_reads = 0;
                end
            end else if (tia_cs_n === 1'b0) begin
                low_cnt++;
            end else if (tia_cs_n === 1'b1 && prev_cs === 1'b0) begin
                if (!skip_len) check("strobe_len", low_cnt, 2);
                if (cur[11] && cur[10:8] == 3'd2 && !dav) lo_reads++;
            end
            prev_cs = tia_cs_n;
        end
    end

    // Response monitor
    initial forever begin
        rsp_t r;
        @(negedge clock);
        if (rsp_valid === 1'b1) begin
            rsp_count++;
            last_rsp_cyc = cyc;
            if (rsp_q.size() == 0) begin
                check("rsp_unexpected", 1, 0);
            end else begin
                r = rsp_q.pop_front();
                check("rsp_data", rsp_data, r.data);
                check("rsp_status", rsp_status, r.status);
                check("rsp_timeout", rsp_timeout, r.timeout);
                check("rsp_latency", cyc - acc_cyc, r.lat);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int n_rsp;
        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_dir = 1'b0;
        cmd_data = 8'h00;

        // Reset values, then the two init writes and the ready delay
        wr(3'd5, 8'h80);
        wr(3'd2, 8'h80);
        repeat (3) @(negedge clock);
        check("rst_cs_n", tia_cs_n, 1);
        check("rst_write_n", tia_write_n, 1);
        check("rst_rs", tia_rs, 0);
        check("rst_data_out", tia_data_out, 0);
        check("rst_data_oe", tia_data_oe, 0);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_status", rsp_status, 0);
        check("rst_rsp_timeout", rsp_timeout, 0);
        reset = 1'b0;
        count_init("init_ready_delay");
        drain("init");

        // Send 0xA5, ACK on first poll, PB = 0x02
        pb_val = 8'h02;
        lo_delay = 1;
        push_send(8'hA5, 1);
        exp_rsp(8'hA5, 2'b10, 1'b0, 28);
        issue(1'b0, 8'hA5);
        drain("send_a5");

        // Receive 0x3C, ACK low on the third poll, PB = 0x01
        pa_val = 8'h3C;
        pb_val = 8'h01;
        lo_delay = 3;
        wr(3'd3, 8'h00);
        wr(3'd2, 8'h00);
        repeat (3) rd(3'd2);
        rd(3'd0);
        wr(3'd2, 8'h80);
        rd(3'd2);
        rd(3'd1);
        exp_rsp(8'h3C, 2'b01, 1'b0, 36);
        issue(1'b1, 8'hEE);
        drain("recv_3c");

        // ACK stuck high: four polls, DAV restored, no PB read
        stuck = 1;
        wr(3'd3, 8'hFF);
        wr(3'd0, 8'h5A);
        wr(3'd2, 8'h00);
        repeat (4) rd(3'd2);
        wr(3'd2, 8'h80);
        exp_rsp(8'h00, 2'b11, 1'b1, 32);
        issue(1'b0, 8'h5A);
        drain("timeout");
        stuck = 0;
        lo_delay = 1;

        // Reset during the WR_PA strobe drops the command and reruns init
        wr(3'd3, 8'hFF);
        wr(3'd0, 8'h77);
        wr(3'd5, 8'h80);
        wr(3'd2, 8'h80);
        n_rsp = rsp_count;
        issue(1'b0, 8'h77);
        n = 0;
        while (!(tia_cs_n === 1'b0 && tia_rs === 3'd0 && tia_write_n === 1'b0) && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("wr_pa_strobe_reached", n < 100, 1);
        skip_len = 1;
        reset = 1'b1;
        @(negedge clock);
        check("abort_cs_n", tia_cs_n, 1);
        check("abort_data_oe", tia_data_oe, 0);
        reset = 1'b0;
        count_init("reinit_ready_delay");
        skip_len = 0;
        drain("reset_abort");
        check("dropped_rsp_count", rsp_count - n_rsp, 0);

        // Back-to-back sends with cmd_valid held high
        pb_val = 8'h03;
        push_send(8'h11, 1);
        push_send(8'h22, 1);
        exp_rsp(8'h11, 2'b11, 1'b0, 28);
        exp_rsp(8'h22, 2'b11, 1'b0, 28);
        wait_ready("b2b_ready");
        cmd_valid = 1'b1;
        cmd_dir = 1'b0;
        cmd_data = 8'h11;
        @(negedge clock);
        cmd_data = 8'h22;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 100) begin
            @(negedge clock);
            n++;
        end
        @(negedge clock);
        cmd_valid = 1'b0;
        // rsp_valid clock, one idle clock, then the accepting edge
        check("b2b_accept_gap", acc_cyc - last_rsp_cyc, 2);
        drain("b2b");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
